proj_hasher: RTL and testbench
==============================

Name: proj_hasher

Overview:
Upstream feeder of proj_sorter. It accepts a stream of set elements with a valid/ready handshake and tags each element with a sequential index within its set. Each element is hashed through a fixed 3-stage pipeline into a HASHER_SORTER_SIGNATURE-wide signature. The block drives the sorter's signature, index and end_sorting inputs every cycle. Because the sorter has no valid input, idle cycles carry an all-ones sentinel signature, which can never displace a real entry.

Parameters:
DATA_LEN, 32, element width; must be ≤ SIGNATURE_LEN; zero-extended into the hash.
INDICE_LEN, proj_pkg::INDICE_LEN, width of the element index.
SIGNATURE_LEN, proj_pkg::HASHER_SORTER_SIGNATURE (32), signature width.
HASH_MULT, 32'h9E3779B1, multiplier constant.
HASH_ADD, 32'h7F4A7C15, additive constant.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_data  in  DATA_LEN  element value
in_valid  in  1  element present
in_last  in  1  element is the last of its set; qualified by in_valid
in_ready  out  1  block accepts an element this cycle
out_signature  out  SIGNATURE_LEN  to sorter in_signature
out_index  out  INDICE_LEN  to sorter in_index
out_end  out  1  to sorter end_sorting
out_overflow  out  1  sticky: the current set exceeded 2^INDICE_LEN elements

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low on rst_n; all state updates on posedge clk.
  - Reset values: out_signature = all-ones, out_index = 0, out_end = 0, out_overflow = 0, in_ready = 0, index counter = 0, pipeline valids = 0, FSM = IDLE.
- Accept rule: an element is accepted when in_valid && in_ready.
- Index counter:
  - Each accepted element takes the current counter value, then the counter increments.
  - The counter wraps at 2^INDICE_LEN. The wrap sets out_overflow, which stays set until the next set starts.
- Hash pipeline (latency 3, one element per cycle, modulo 2^32):
  - S1: p = zext(in_data) * HASH_MULT, low 32 bits.
  - S2: q = p + HASH_ADD.
  - S3: s = q ^ (q >> 16). If s == all-ones, output all-ones minus 1, so the sentinel stays unique.
- Output timing:
  - An element accepted at cycle N appears on out_signature/out_index at cycle N+3.
  - Cycles without a valid S3 result drive out_signature = all-ones and out_index = 0.
- FSM:
  - IDLE: in_ready = 0 for this single cycle, then go to RUN.
  - RUN: in_ready = 1. Accepting in_last goes to DRAIN.
  - DRAIN: in_ready = 0. Stay until the last element's S3 result is on the outputs. That same cycle, out_end = 1 (aligned with the last signature), then go to GAP.
  - GAP: one cycle with in_ready = 0 and the sentinel on the outputs. Clear the counter and out_overflow, then go to RUN.
- out_end is a single-cycle pulse per set, always coincident with that set's last valid signature.
- Back-to-back sets: the minimum distance from one in_last acceptance to the next set's first acceptance is 5 cycles.
- A set of one element (in_last on the first element) is legal: that element has index 0 and out_end at N+3.
- in_last without in_valid is ignored.
- Reset mid-set discards all in-flight elements; no out_end is emitted for that set.

Optional Feature:
Macro PROJ_HASHER_SEED_EN.
- Defined: adds input in_seed[SIGNATURE_LEN-1:0]. The seed is captured on the first acceptance of each set and replaces HASH_ADD in S2 for that whole set, allowing different MinHash permutations.
- Undefined: no port; HASH_ADD is used for every set.

Decomposition:
- proj_pkg gains:
  - HASHER_MULT and HASHER_ADD constants.
  - HASHER_LATENCY = 3.
  - SIGNATURE_SENTINEL = all-ones.
  - typedef hasher_state_t {IDLE, RUN, DRAIN, GAP}.
  - typedef packed struct hash_stage_t {valid, index, value, last}.
- One sub-module, proj_hash_pipe, holds the 3-stage arithmetic pipeline with valid/index/last sideband. The top holds the FSM, index counter and overflow logic.

Test Plan:
- Single element, in_data = 1, in_last = 1, after reset → 3 cycles later out_signature = 32'h1D81E847, out_index = 0, out_end = 1 that cycle; all-ones before and after.
- in_data = 0, then 1, then 2 (last) streamed in consecutive cycles → consecutive outputs with indices 0, 1, 2; first signature 32'h7F4A035F, second 32'h1D81E847; out_end only with index 2.
- Two back-to-back sets → in_ready low exactly through DRAIN + GAP; second set restarts at index 0; exactly one out_end per set.
- 2^INDICE_LEN + 1 elements in one set → out_overflow rises on the wrap (last index = 0), stays set, and clears in GAP.
- rst_n low for one cycle while 2 elements are in flight → outputs return to sentinel; no out_end; next set starts at index 0.
- Connect to proj_sorter with 20 random elements → sort_valid coincides with out_end; the sorter's list matches a reference model of the smallest signatures.

Source files
------------

// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared widths, hasher constants, states and stage type
// Package only; no ports.
package proj_pkg;

   localparam int INDICE_LEN              = 4;
   localparam int HASHER_SORTER_SIGNATURE = 32;

   localparam logic [31:0] HASHER_MULT    = 32'h9E3779B1;
   localparam logic [31:0] HASHER_ADD     = 32'h7F4A7C15;
   localparam int          HASHER_LATENCY = 3;

   // Idle cycles carry this value; real signatures are remapped away from it.
   localparam logic [HASHER_SORTER_SIGNATURE-1:0] SIGNATURE_SENTINEL = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      GAP
   } hasher_state_t;

   typedef struct packed {
      logic                               valid;
      logic [INDICE_LEN-1:0]              index;
      logic [HASHER_SORTER_SIGNATURE-1:0] value;
      logic                               last;
   } hash_stage_t;

endpackage

// File: rtl/proj_hash_pipe.sv
// rtl/proj_hash_pipe.sv - 3-stage multiply/add/xor-shift hash with index/last sideband
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid               element accepted this cycle
//   in_data, in_index      element value and its index within the set
//   in_last                element closes its set
//   add_value              additive constant used in stage 2
//   out_signature          stage-3 signature, sentinel when no valid result
//   out_index              stage-3 index, 0 when no valid result
//   out_end                stage-3 result is valid and closes its set
module proj_hash_pipe
   import proj_pkg::*;
#(
   parameter int                       DATA_LEN      = 32,
   parameter int                       INDICE_LEN    = proj_pkg::INDICE_LEN,
   parameter int                       SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
   parameter logic [SIGNATURE_LEN-1:0] HASH_MULT     = HASHER_MULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_LEN-1:0]      in_data,
   input  logic [INDICE_LEN-1:0]    in_index,
   input  logic                     in_last,
   input  logic [SIGNATURE_LEN-1:0] add_value,
   output logic [SIGNATURE_LEN-1:0] out_signature,
   output logic [INDICE_LEN-1:0]    out_index,
   output logic                     out_end
);

   hash_stage_t s1, s2, s3;

   logic [SIGNATURE_LEN-1:0] data_ext;
   logic [SIGNATURE_LEN-1:0] p_next;
   logic [SIGNATURE_LEN-1:0] q_next;
   logic [SIGNATURE_LEN-1:0] mix;
   logic [SIGNATURE_LEN-1:0] s_next;

   always_comb begin
      data_ext                 = '0;
      data_ext[DATA_LEN-1:0]   = in_data;
      p_next                   = data_ext * HASH_MULT;
      q_next                   = s1.value + add_value;
      mix                      = s2.value ^ (s2.value >> 16);
      // Keep the sentinel unique: a genuine all-ones hash is nudged down by one.
      s_next                   = (mix == SIGNATURE_SENTINEL) ? (SIGNATURE_SENTINEL - 1'b1) : mix;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '{valid: 1'b0, index: '0, value: SIGNATURE_SENTINEL, last: 1'b0};
      end else begin
         s1 <= '{valid: in_valid, index: in_index, value: p_next, last: in_valid & in_last};
         s2 <= '{valid: s1.valid, index: s1.index, value: q_next, last: s1.last};
         if (s2.valid) begin
            s3 <= '{valid: 1'b1, index: s2.index, value: s_next, last: s2.last};
         end else begin
            s3 <= '{valid: 1'b0, index: '0, value: SIGNATURE_SENTINEL, last: 1'b0};
         end
      end
   end

   assign out_signature = s3.value;
   assign out_index     = s3.index;
   assign out_end       = s3.valid & s3.last;

endmodule

// File: rtl/proj_hasher.sv
// rtl/proj_hasher.sv - element stream to sorter feeder: indexing, hashing, set framing
// Optional macro PROJ_HASHER_SEED_EN adds in_seed, captured at each set's first
// acceptance and used as the stage-2 additive constant for that set.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_seed                        (PROJ_HASHER_SEED_EN only) per-set additive seed
//   in_data, in_valid, in_last     element stream, accepted on in_valid && in_ready
//   in_ready                       high only in RUN
//   out_signature, out_index       to sorter, sentinel/0 on idle cycles
//   out_end                        one-cycle pulse with the set's last signature
//   out_overflow                   sticky: set grew past 2^INDICE_LEN elements
module proj_hasher
   import proj_pkg::*;
#(
   parameter int                       DATA_LEN      = 32,
   parameter int                       INDICE_LEN    = proj_pkg::INDICE_LEN,
   parameter int                       SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
   parameter logic [SIGNATURE_LEN-1:0] HASH_MULT     = HASHER_MULT,
   parameter logic [SIGNATURE_LEN-1:0] HASH_ADD      = HASHER_ADD
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef PROJ_HASHER_SEED_EN
   input  logic [SIGNATURE_LEN-1:0] in_seed,
`endif
   input  logic [DATA_LEN-1:0]      in_data,
   input  logic                     in_valid,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic [SIGNATURE_LEN-1:0] out_signature,
   output logic [INDICE_LEN-1:0]    out_index,
   output logic                     out_end,
   output logic                     out_overflow
);

   hasher_state_t           state, state_next;
   logic                    accept;
   logic [INDICE_LEN-1:0]   cnt;
   logic                    wrapped;
   logic [SIGNATURE_LEN-1:0] add_value;

   assign accept = in_valid && in_ready;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE:  state_next = RUN;
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_next = DRAIN;
         end
         // Leave once the set's last result is on the outputs.
         DRAIN: if (out_end) state_next = GAP;
         GAP:   state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         wrapped      <= 1'b0;
         out_overflow <= 1'b0;
      end else begin
         state <= state_next;
         if (state == GAP) begin
            cnt          <= '0;
            wrapped      <= 1'b0;
            out_overflow <= 1'b0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
            // wrapped marks that index space is used up; the next element overflows.
            if (cnt == '1) wrapped <= 1'b1;
            if (wrapped) out_overflow <= 1'b1;
         end
      end
   end

`ifdef PROJ_HASHER_SEED_EN
   logic                     in_set;
   logic [SIGNATURE_LEN-1:0] seed_q;

   // The first element reaches stage 2 one cycle after capture, so seed_q is
   // already valid for it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_set <= 1'b0;
         seed_q <= HASH_ADD;
      end else if (state == GAP) begin
         in_set <= 1'b0;
      end else if (accept) begin
         in_set <= 1'b1;
         if (!in_set) seed_q <= in_seed;
      end
   end

   assign add_value = seed_q;
`else
   assign add_value = HASH_ADD;
`endif

   proj_hash_pipe #(
      .DATA_LEN      (DATA_LEN),
      .INDICE_LEN    (INDICE_LEN),
      .SIGNATURE_LEN (SIGNATURE_LEN),
      .HASH_MULT     (HASH_MULT)
   ) u_pipe (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (accept),
      .in_data       (in_data),
      .in_index      (cnt),
      .in_last       (in_last),
      .add_value     (add_value),
      .out_signature (out_signature),
      .out_index     (out_index),
      .out_end       (out_end)
   );

endmodule

// File: tb/tb_proj_hasher.sv
// tb/tb_proj_hasher.sv - directed self-checking bench for proj_hasher
module tb_proj_hasher;
   import proj_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_signature;
   logic [INDICE_LEN-1:0] out_index;
   logic        out_end;
   logic        out_overflow;
`ifdef PROJ_HASHER_SEED_EN
   logic [31:0] in_seed;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   proj_hasher dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef PROJ_HASHER_SEED_EN
      .in_seed       (in_seed),
`endif
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .out_signature (out_signature),
      .out_index     (out_index),
      .out_end       (out_end),
      .out_overflow  (out_overflow)
   );

   localparam logic [31:0] SENT = 32'hFFFF_FFFF;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic drive(input logic [31:0] d, input logic v, input logic l);
      in_data  = d;
      in_valid = v;
      in_last  = l;
   endtask

   initial begin
      int low_cnt;
      int end_cnt;
      int n;

      rst_n = 1'b0;
      drive(32'd0, 1'b0, 1'b0);
`ifdef PROJ_HASHER_SEED_EN
      in_seed = HASHER_ADD;
`endif
      tick();
      tick();
      chk("rst_sig", out_signature, SENT);
      chk("rst_idx", {28'd0, out_index}, 32'd0);
      chk("rst_end", {31'd0, out_end}, 32'd0);
      chk("rst_ovf", {31'd0, out_overflow}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", {31'd0, in_ready}, 32'd0);

      // Single-element set, data 1
      wait_ready("t1_ready");
      drive(32'd1, 1'b1, 1'b1);
      tick();
      drive(32'd0, 1'b0, 1'b0);
      for (int i = 1; i < HASHER_LATENCY; i++) begin
         chk("t1_pre_sig", out_signature, SENT);
         chk("t1_pre_end", {31'd0, out_end}, 32'd0);
         chk("t1_pre_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      chk("t1_sig", out_signature, 32'h1D81E847);
      chk("t1_idx", {28'd0, out_index}, 32'd0);
      chk("t1_end", {31'd1 & 31'd0, out_end}, 32'd1);
      tick();
      chk("t1_gap_sig", out_signature, SENT);
      chk("t1_gap_end", {31'd0, out_end}, 32'd0);
      chk("t1_gap_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t1_run_ready", {31'd0, in_ready}, 32'd1);

      // Three-element set 0,1,2 streamed back to back
      drive(32'd0, 1'b1, 1'b0); tick();
      drive(32'd1, 1'b1, 1'b0); tick();
      drive(32'd2, 1'b1, 1'b1); tick();
      drive(32'd0, 1'b0, 1'b0);
      chk("t2_sig0", out_signature, 32'h7F4A035F);
      chk("t2_idx0", {28'd0, out_index}, 32'd0);
      chk("t2_end0", {31'd0, out_end}, 32'd0);
      tick();
      chk("t2_sig1", out_signature, 32'h1D81E847);
      chk("t2_idx1", {28'd0, out_index}, 32'd1);
      chk("t2_end1", {31'd0, out_end}, 32'd0);
      tick();
      chk("t2_sig2", out_signature, 32'hBBB9D4CE);
      chk("t2_idx2", {28'd0, out_index}, 32'd2);
      chk("t2_end2", {31'd0, out_end}, 32'd1);
      chk("t2_drain_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t2_gap_sig", out_signature, SENT);
      tick();
      chk("t2_run_ready", {31'd0, in_ready}, 32'd1);

      // Two-element set: count ready-low cycles and out_end pulses
      drive(32'd5, 1'b1, 1'b0); tick();
      chk("t3_first_idx_later", {31'd0, in_ready}, 32'd1);
      drive(32'd6, 1'b1, 1'b1); tick();
      drive(32'd0, 1'b0, 1'b0);
      low_cnt = 0;
      end_cnt = 0;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         low_cnt++;
         if (out_end === 1'b1) begin
            end_cnt++;
            chk("t3_end_idx", {28'd0, out_index}, 32'd1);
         end
         tick();
         n++;
      end
      chk("t3_ready_low", low_cnt, 32'd4);
      chk("t3_end_count", end_cnt, 32'd1);

      // Overflow: 17 elements into a 16-entry index space
      for (int i = 0; i < 17; i++) begin
         drive(i, 1'b1, (i == 16));
         tick();
         if (i == 15) chk("t4_ovf_before", {31'd0, out_overflow}, 32'd0);
      end
      drive(32'd0, 1'b0, 1'b0);
      chk("t4_ovf_rise", {31'd0, out_overflow}, 32'd1);
      chk("t4_idx14", {28'd0, out_index}, 32'd14);
      tick();
      chk("t4_idx15", {28'd0, out_index}, 32'd15);
      chk("t4_end15", {31'd0, out_end}, 32'd0);
      tick();
      chk("t4_last_idx", {28'd0, out_index}, 32'd0);
      chk("t4_last_end", {31'd0, out_end}, 32'd1);
      chk("t4_ovf_hold", {31'd0, out_overflow}, 32'd1);
      tick();
      chk("t4_ovf_gap", {31'd0, out_overflow}, 32'd1);
      tick();
      chk("t4_ovf_clear", {31'd0, out_overflow}, 32'd0);
      chk("t4_run_ready", {31'd0, in_ready}, 32'd1);

      // Reset with two elements in flight
      drive(32'd1, 1'b1, 1'b0); tick();
      drive(32'd2, 1'b1, 1'b0); tick();
      drive(32'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_rst_sig", out_signature, SENT);
      chk("t5_rst_end", {31'd0, out_end}, 32'd0);
      chk("t5_rst_ready", {31'd0, in_ready}, 32'd0);
      end_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_end === 1'b1 || out_signature !== SENT) end_cnt++;
         tick();
      end
      chk("t5_no_output", end_cnt, 32'd0);
      wait_ready("t5_ready");
      drive(32'd0, 1'b1, 1'b1); tick();
      drive(32'd0, 1'b0, 1'b0);
      tick();
      tick();
      chk("t5_sig", out_signature, 32'h7F4A035F);
      chk("t5_idx", {28'd0, out_index}, 32'd0);
      chk("t5_end", {31'd0, out_end}, 32'd1);

      // in_last without in_valid must not close a set
      tick();
      tick();
      wait_ready("t6_ready");
      drive(32'd9, 1'b0, 1'b1); tick();
      chk("t6_still_run", {31'd0, in_ready}, 32'd1);
      drive(32'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
